mmcam_mem_ctrl: RTL and testbench

Synchronous sequencer for the matching-memory data store behind the MMCAM search stage. It accepts each 38-bit token together with the CAM verdict (WR_E / DEL / ADDR) for that token.
- On a CAM miss it parks the token's operand in a 64-entry data RAM.
- On a hit it reads the partner operand back and emits a paired 54-bit firing packet to the execution side.
- It tracks occupancy and flags protocol errors.

---
 rtl/mmcam_mem_ctrl_pkg.sv | 32 +++
 rtl/mmcam_data_ram.sv | 20 ++
 rtl/mmcam_mem_ctrl.sv | 138 +++++++++++++
 tb/tb_mmcam_mem_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcam_mem_ctrl_pkg.sv
// Shared sizes, packet field positions, FSM encoding and error codes for the
// MMCAM matching-memory controller.
package mmcam_mem_ctrl_pkg;

  localparam int ENTRIES   = 64;
  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 18;
  localparam int HDR_W     = 18;
  localparam int CNT_W     = ADDR_W + 1;
  localparam int PKT_IN_W  = HDR_W + 2 + DATA_W;
  localparam int PKT_OUT_W = HDR_W + 2 * DATA_W;

  localparam int HDR_MSB  = 37;
  localparam int HDR_LSB  = 20;
  localparam int LR_BIT   = 19;
  localparam int MF_BIT   = 18;
  localparam int DATA_MSB = 17;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_PAIR  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE        = 2'b00;
  localparam logic [1:0] ERR_WR_VALID    = 2'b01;
  localparam logic [1:0] ERR_DEL_INVALID = 2'b10;
  localparam logic [1:0] ERR_PROTO       = 2'b11;

endpackage

// File: rtl/mmcam_data_ram.sv
// Single-port operand store: synchronous write, registered read-first output.
// No reset so it maps onto block RAM.
module mmcam_data_ram
  import mmcam_mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mmcam_mem_ctrl.sv
// Matching-memory sequencer: parks unmatched operands on a CAM miss, pairs
// them with the incoming operand on a hit, and tracks occupancy and errors.
module mmcam_mem_ctrl
  import mmcam_mem_ctrl_pkg::*;
(
  input  logic                 CP,
  input  logic                 MR,
  input  logic                 Send_in,
  output logic                 Ack_out,
  input  logic [PKT_IN_W-1:0]  PACKET_IN,
  input  logic                 WR_E,
  input  logic                 DEL,
  input  logic [ADDR_W-1:0]    ADDR,
  output logic                 Send_out,
  input  logic                 Ack_in,
  output logic [PKT_OUT_W-1:0] PACKET_OUT,
  output logic [CNT_W-1:0]     CNT,
  output logic                 FULL,
  output logic                 ERR,
  output logic [1:0]           ERR_CODE
);

  state_t                 state_reg;
  logic [ENTRIES-1:0]     valid_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   err_reg;
  logic [1:0]             err_code_reg;
  logic                   send_out_reg;
  logic [PKT_OUT_W-1:0]   packet_out_reg;
  logic [HDR_W-1:0]       hdr_reg;
  logic                   lr_reg;
  logic [DATA_W-1:0]      data_reg;
  logic [ADDR_W-1:0]      addr_reg;
  logic [DATA_W-1:0]      ram_rdata;
  logic                   err_hit;
  logic [1:0]             err_cause;

  mmcam_data_ram u_ram (
    .clk   (CP),
    .we    (state_reg == ST_WRITE),
    .addr  (addr_reg),
    .wdata (data_reg),
    .rdata (ram_rdata)
  );

  // Error detection is kept apart so only the first cause is latched below.
  always_comb begin
    err_hit   = 1'b0;
    err_cause = ERR_NONE;
    case (state_reg)
      ST_IDLE:
        if (Send_in && PACKET_IN[MF_BIT] && (WR_E == DEL)) begin
          err_hit   = 1'b1;
          err_cause = ERR_PROTO;
        end
      ST_WRITE:
        if (valid_reg[addr_reg]) begin
          err_hit   = 1'b1;
          err_cause = ERR_WR_VALID;
        end
      ST_READ:
        if (!valid_reg[addr_reg]) begin
          err_hit   = 1'b1;
          err_cause = ERR_DEL_INVALID;
        end
      default: ;
    endcase
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      state_reg      <= ST_IDLE;
      valid_reg      <= '0;
      cnt_reg        <= '0;
      err_reg        <= 1'b0;
      err_code_reg   <= ERR_NONE;
      send_out_reg   <= 1'b0;
      packet_out_reg <= '0;
    end else begin
      if (err_hit) begin
        err_reg <= 1'b1;
        if (!err_reg) err_code_reg <= err_cause;
      end
      case (state_reg)
        ST_IDLE:
          if (Send_in) begin
            hdr_reg  <= PACKET_IN[HDR_MSB:HDR_LSB];
            lr_reg   <= PACKET_IN[LR_BIT];
            data_reg <= PACKET_IN[DATA_MSB:0];
            addr_reg <= ADDR;
            if (!PACKET_IN[MF_BIT]) begin
              packet_out_reg <= {PACKET_IN[HDR_MSB:HDR_LSB], PACKET_IN[DATA_MSB:0],
                                 {DATA_W{1'b0}}};
              send_out_reg   <= 1'b1;
              state_reg      <= ST_OUT;
            end else if (WR_E && !DEL) begin
              state_reg <= ST_WRITE;
            end else if (DEL && !WR_E) begin
              state_reg <= ST_READ;
            end
          end
        ST_WRITE: begin
          valid_reg[addr_reg] <= 1'b1;
          if (!valid_reg[addr_reg] && cnt_reg != CNT_W'(ENTRIES))
            cnt_reg <= cnt_reg + 1'b1;
          state_reg <= ST_IDLE;
        end
        ST_READ: begin
          valid_reg[addr_reg] <= 1'b0;
          if (valid_reg[addr_reg] && cnt_reg != '0)
            cnt_reg <= cnt_reg - 1'b1;
          state_reg <= ST_PAIR;
        end
        ST_PAIR: begin
          packet_out_reg <= lr_reg ? {hdr_reg, ram_rdata, data_reg}
                                   : {hdr_reg, data_reg, ram_rdata};
          send_out_reg   <= 1'b1;
          state_reg      <= ST_OUT;
        end
        ST_OUT:
          if (Ack_in) begin
            send_out_reg <= 1'b0;
            state_reg    <= ST_IDLE;
          end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign Ack_out    = (state_reg == ST_IDLE) && !MR;
  assign Send_out   = send_out_reg;
  assign PACKET_OUT = packet_out_reg;
  assign CNT        = cnt_reg;
  assign FULL       = (cnt_reg == CNT_W'(ENTRIES));
  assign ERR        = err_reg;
  assign ERR_CODE   = err_code_reg;

endmodule

// File: tb/tb_mmcam_mem_ctrl.sv
// Scoreboard bench for mmcam_mem_ctrl: a matching-memory reference model
// predicts packets and status; a monitor drains packets with random backpressure.
module tb_mmcam_mem_ctrl;
  import mmcam_mem_ctrl_pkg::*;

  logic        CP = 1'b0;
  logic        MR = 1'b1;
  logic        Send_in = 1'b0;
  logic        Ack_in = 1'b0;
  logic        WR_E = 1'b0;
  logic        DEL = 1'b0;
  logic [37:0] PACKET_IN = '0;
  logic [5:0]  ADDR = '0;
  logic        Ack_out, Send_out, FULL, ERR;
  logic [53:0] PACKET_OUT;
  logic [6:0]  CNT;
  logic [1:0]  ERR_CODE;

  mmcam_mem_ctrl dut (
    .CP(CP), .MR(MR), .Send_in(Send_in), .Ack_out(Ack_out), .PACKET_IN(PACKET_IN),
    .WR_E(WR_E), .DEL(DEL), .ADDR(ADDR), .Send_out(Send_out), .Ack_in(Ack_in),
    .PACKET_OUT(PACKET_OUT), .CNT(CNT), .FULL(FULL), .ERR(ERR), .ERR_CODE(ERR_CODE)
  );

  always #5 CP = ~CP;

  typedef struct {
    logic [53:0] pkt;
    logic [53:0] mask;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  exp_t        sb_q[$];
  bit          ack_en = 1'b1;

  // Reference model: which slots hold an operand, what they hold, and whether
  // the RAM slot was ever written (RAM survives reset, so data persists).
  bit          m_valid[64];
  bit          m_written[64];
  logic [17:0] m_data[64];
  int          m_cnt;
  bit          m_err;
  logic [1:0]  m_code;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_cnt  = 0;
    m_err  = 1'b0;
    m_code = 2'b00;
    sb_q.delete();
  endtask

  task automatic model_error(input logic [1:0] code);
    if (!m_err) begin
      m_err  = 1'b1;
      m_code = code;
    end
  endtask

  task automatic model_accept(input logic [17:0] hdr, input logic lr, input logic mf,
                              input logic [17:0] data, input logic we, input logic de,
                              input logic [5:0] addr);
    exp_t e;
    if (!mf) begin
      e.pkt  = {hdr, data, 18'h0};
      e.mask = '1;
      sb_q.push_back(e);
    end else if (we == de) begin
      model_error(2'b11);
    end else if (we) begin
      if (m_valid[addr]) model_error(2'b01);
      else m_cnt++;
      m_valid[addr]   = 1'b1;
      m_written[addr] = 1'b1;
      m_data[addr]    = data;
    end else begin
      if (!m_valid[addr]) model_error(2'b10);
      else m_cnt--;
      m_valid[addr] = 1'b0;
      if (lr) begin
        e.pkt  = {hdr, m_data[addr], data};
        e.mask = m_written[addr] ? '1 : {18'h3FFFF, 18'h0, 18'h3FFFF};
      end else begin
        e.pkt  = {hdr, data, m_data[addr]};
        e.mask = m_written[addr] ? '1 : {18'h3FFFF, 18'h3FFFF, 18'h0};
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic send_token(input logic [17:0] hdr, input logic lr, input logic mf,
                            input logic [17:0] data, input logic we, input logic de,
                            input logic [5:0] addr, input bit chk_lat);
    int n = 0;
    @(negedge CP);
    PACKET_IN = {hdr, lr, mf, data};
    WR_E = we;
    DEL = de;
    ADDR = addr;
    Send_in = 1'b1;
    while (!Ack_out) begin
      @(negedge CP);
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=no_ack required=ack");
        Send_in = 1'b0;
        return;
      end
    end
    @(posedge CP);
    model_accept(hdr, lr, mf, data, we, de, addr);
    @(negedge CP);
    Send_in = 1'b0;
    WR_E = 1'b0;
    DEL = 1'b0;
    if (chk_lat) begin
      if (!mf) begin
        check("pt_send_t1", Send_out, 1);
      end else if (we && !de) begin
        check("wr_ack_t1", Ack_out, 0);
        @(negedge CP);
        check("wr_ack_t2", Ack_out, 1);
      end else if (de && !we) begin
        check("rd_send_t1", Send_out, 0);
        @(negedge CP);
        check("rd_send_t2", Send_out, 0);
        @(negedge CP);
        check("rd_send_t3", Send_out, 1);
      end
    end
  endtask

  task automatic wait_status(input string tag);
    int n = 0;
    while (!Ack_out) begin
      @(negedge CP);
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL idle_timeout %s actual=busy required=idle", tag);
        return;
      end
    end
    check("cnt", CNT, m_cnt);
    check("full", FULL, m_cnt == 64);
    check("err", ERR, m_err);
    check("err_code", ERR_CODE, m_code);
  endtask

  task automatic do_reset();
    @(negedge CP);
    MR = 1'b1;
    Send_in = 1'b0;
    repeat (2) @(negedge CP);
    check("rst_ack_low", Ack_out, 0);
    MR = 1'b0;
    model_reset();
    @(negedge CP);
    check("rst_ack", Ack_out, 1);
    check("rst_send", Send_out, 0);
    check("rst_pkt", PACKET_OUT, 0);
    check("rst_cnt", CNT, 0);
    check("rst_full", FULL, 0);
    check("rst_err", {ERR, ERR_CODE}, 0);
  endtask

  // Monitor: randomly accepts packets, checks hold stability and scoreboard.
  initial begin
    logic [53:0] prev = '0;
    bit          held = 1'b0;
    exp_t        e;
    forever begin
      @(negedge CP);
      if (MR) begin
        Ack_in = 1'b0;
        held = 1'b0;
      end else begin
        if (Send_out && held) check("out_hold", PACKET_OUT, prev);
        Ack_in = ack_en && ($urandom_range(0, 1) == 1);
        if (Send_out && Ack_in) begin
          $display("pkt out %h", PACKET_OUT);
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pkt actual=%h required=none", PACKET_OUT);
          end else begin
            e = sb_q.pop_front();
            check("pkt", PACKET_OUT & e.mask, e.pkt & e.mask);
          end
        end
        held = Send_out && !Ack_in;
        prev = PACKET_OUT;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      m_written[i] = 1'b0;
      m_data[i]    = '0;
    end
    model_reset();
    do_reset();

    // Pass-through held under backpressure for 5 cycles.
    ack_en = 1'b0;
    send_token(18'h000A5, 1'b0, 1'b0, 18'h12345, 1'b0, 1'b0, 6'd0, 1'b1);
    repeat (5) begin
      @(negedge CP);
      check("pt_hold_valid", Send_out, 1);
    end
    ack_en = 1'b1;
    wait_status("pt");

    // Miss then hit at address 5.
    send_token(18'h00001, 1'b1, 1'b1, 18'h00111, 1'b1, 1'b0, 6'd5, 1'b1);
    wait_status("wr5");
    send_token(18'h00002, 1'b0, 1'b1, 18'h00222, 1'b0, 1'b1, 6'd5, 1'b1);
    wait_status("del5");

    // Fill every slot, then overwrite slot 0.
    for (int a = 0; a < 64; a++)
      send_token(18'($urandom), 1'($urandom), 1'b1, 18'($urandom), 1'b1, 1'b0, 6'(a), 1'b0);
    wait_status("fill");
    send_token(18'h00003, 1'b0, 1'b1, 18'h3FFFF, 1'b1, 1'b0, 6'd0, 1'b0);
    wait_status("overfill");

    // Delete of an empty slot, then a malformed token keeps the first code.
    do_reset();
    send_token(18'h00004, 1'b1, 1'b1, 18'h00444, 1'b0, 1'b1, 6'd9, 1'b1);
    wait_status("del_empty");
    send_token(18'h00005, 1'b0, 1'b1, 18'h00555, 1'b1, 1'b1, 6'd9, 1'b0);
    wait_status("both");

    // Randomized mix over a small address range so hits are frequent.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      int r;
      logic we, de;
      r = int'($urandom_range(0, 9));
      we = (r < 5) || (r == 9);
      de = (r >= 5 && r < 9) || (r == 9);
      if (r == 9 && $urandom_range(0, 1) == 1) begin
        we = 1'b0;
        de = 1'b0;
      end
      send_token(18'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0), 18'($urandom),
                 we, de, 6'($urandom_range(0, 15)), 1'b0);
      wait_status("rand");
    end

    // Reset while a packet is waiting in OUT.
    do_reset();
    send_token(18'h00006, 1'b0, 1'b1, 18'h00666, 1'b1, 1'b0, 6'd9, 1'b0);
    wait_status("pre_rst_wr");
    ack_en = 1'b0;
    send_token(18'h00007, 1'b0, 1'b0, 18'h00777, 1'b0, 1'b0, 6'd0, 1'b1);
    @(negedge CP);
    MR = 1'b1;
    @(negedge CP);
    check("midrst_send", Send_out, 0);
    check("midrst_pkt", PACKET_OUT, 0);
    check("midrst_cnt", CNT, 0);
    MR = 1'b0;
    model_reset();
    ack_en = 1'b1;
    @(negedge CP);
    check("midrst_ack", Ack_out, 1);
    send_token(18'h00008, 1'b0, 1'b1, 18'h00888, 1'b0, 1'b1, 6'd9, 1'b0);
    wait_status("post_rst_del");

    repeat (20) @(negedge CP);
    check("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
